// File: rtl/moxie_wb_pkg.sv
// Shared types and sizing helpers for the MoxieLite-to-Wishbone bridge.
package moxie_wb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StGap,
        StDone
    } bridge_state_e;

    // Counter widths sized for the largest legal TIMEOUT_CYC and MAX_RETRY.
    localparam int unsigned TO_CNT_W  = $clog2(65535 + 1);
    localparam int unsigned RTY_CNT_W = $clog2(15 + 1);

    // SEL_W = DATA_W/8 for a given data width.
    function automatic int unsigned sel_w(int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/moxie_wb_watchdog.sv
// Bus-timeout and retry counters for the bridge, with clear/increment controls and limit flags.
module moxie_wb_watchdog
    import moxie_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic to_clr,
    input  logic to_inc,
    input  logic rty_clr,
    input  logic rty_inc,
    output logic to_expired,
    output logic rty_exhausted
);

    localparam logic [TO_CNT_W-1:0]  ToLast = TO_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RTY_CNT_W-1:0] RtyMax = RTY_CNT_W'(MAX_RETRY);

    logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic [RTY_CNT_W-1:0] rty_cnt_q, rty_cnt_d;

    always_comb begin
        to_cnt_d  = to_cnt_q;
        rty_cnt_d = rty_cnt_q;
        if (to_clr) begin
            to_cnt_d = '0;
        end else if (to_inc && (to_cnt_q != '1)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (rty_clr) begin
            rty_cnt_d = '0;
        end else if (rty_inc && (rty_cnt_q != '1)) begin
            rty_cnt_d = rty_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q  <= '0;
            rty_cnt_q <= '0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            rty_cnt_q <= rty_cnt_d;
        end
    end

    // Flag is raised during the TIMEOUT_CYC-th BUS cycle so cyc stays up exactly that long.
    assign to_expired    = (to_cnt_q >= ToLast);
    assign rty_exhausted = (rty_cnt_q >= RtyMax);

endmodule

// File: rtl/moxie_wb_bridge.sv
// Registered MoxieLite CPU bus to Wishbone B4 classic master bridge.
// Define WB_POSTED_WRITE_EN to let writes complete to the CPU while the bus cycle runs.
module moxie_wb_bridge
    import moxie_wb_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W-1:0]   cpu_dout_i,
    output logic [DATA_W-1:0]   cpu_din_o,
    input  logic                cpu_rd_n_i,
    input  logic                cpu_wr_n_i,
    input  logic [DATA_W/8-1:0] cpu_be_n_i,
    output logic                cpu_wait_n_o,
    output logic                cpu_buserr_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_rty_i
);

    localparam int unsigned        SelW    = sel_w(DATA_W);
    localparam logic [ADDR_W-1:0]  AdrMask = ~ADDR_W'(SelW - 1);
`ifdef WB_POSTED_WRITE_EN
    localparam bit Posted = 1'b1;
`else
    localparam bit Posted = 1'b0;
`endif

    bridge_state_e     state_q, state_d, fin_state;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              buserr_q, buserr_d;

    logic req, req_we;
    logic bus_fail, bus_ok, bus_rty;
    logic to_clr, to_inc, rty_clr, rty_inc;
    logic to_expired, rty_exhausted;

    assign req    = !cpu_rd_n_i || !cpu_wr_n_i;
    assign req_we = !cpu_wr_n_i;

    // Response priority err > ack > rty; timeout and exhausted retry count as err.
    assign bus_fail = wb_err_i || to_expired || (!wb_ack_i && wb_rty_i && rty_exhausted);
    assign bus_ok   = !wb_err_i && !to_expired && wb_ack_i;
    assign bus_rty  = !wb_err_i && !to_expired && !wb_ack_i && wb_rty_i && !rty_exhausted;

    assign to_inc = (state_q == StBus);

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        din_d     = din_q;
        buserr_d  = 1'b0;
        to_clr    = 1'b0;
        rty_clr   = 1'b0;
        rty_inc   = 1'b0;
        // Posted writes have already released the CPU, so they skip DONE.
        fin_state = (Posted && we_q) ? StIdle : StDone;

        unique case (state_q)
            StIdle: begin
                to_clr  = 1'b1;
                rty_clr = 1'b1;
                if (req) begin
                    adr_d   = cpu_addr_i & AdrMask;
                    dat_d   = cpu_dout_i;
                    we_d    = req_we;
                    sel_d   = req_we ? ~cpu_be_n_i : '1;
                    state_d = StBus;
                end
            end
            StBus: begin
                if (bus_fail) begin
                    buserr_d = 1'b1;
                    if (!we_q) din_d = '1;
                    state_d = fin_state;
                end else if (bus_ok) begin
                    if (!we_q) din_d = wb_dat_i;
                    state_d = fin_state;
                end else if (bus_rty) begin
                    rty_inc = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                to_clr  = 1'b1;
                state_d = StBus;
            end
            StDone: begin
                to_clr  = 1'b1;
                rty_clr = 1'b1;
                state_d = StIdle;
            end
        endcase

        cyc_d = (state_d == StBus);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            din_q    <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            cyc_q    <= cyc_d;
            din_q    <= din_d;
            buserr_q <= buserr_d;
        end
    end

    moxie_wb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .MAX_RETRY  (MAX_RETRY)
    ) u_watchdog (
        .clk          (clk_i),
        .rst          (rst_i),
        .to_clr       (to_clr),
        .to_inc       (to_inc),
        .rty_clr      (rty_clr),
        .rty_inc      (rty_inc),
        .to_expired   (to_expired),
        .rty_exhausted(rty_exhausted)
    );

    assign cpu_wait_n_o = (state_q == StDone) ||
                          ((state_q == StIdle) && (!req || (Posted && req_we)));

    assign cpu_din_o    = din_q;
    assign cpu_buserr_o = buserr_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;

endmodule

// File: tb/tb_moxie_wb_bridge.sv
// Scoreboard bench for moxie_wb_bridge: 16-bit instance for most scenarios, 32-bit for byte lanes.
module tb_moxie_wb_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit DUT signals
    logic [31:0] addr = '0;
    logic [15:0] dout = '0;
    logic [15:0] din;
    logic        rd_n = 1'b1, wr_n = 1'b1;
    logic [1:0]  be_n = 2'b11;
    logic        wait_n, buserr;
    logic [31:0] adr;
    logic [15:0] wdat;
    logic [15:0] rdata = '0;
    logic [1:0]  sel;
    logic        we, cyc, stb;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

    // 32-bit DUT signals
    logic [31:0] addr32 = '0, dout32 = '0, din32, adr32, wdat32;
    logic [31:0] rdat32 = '0;
    logic        rd_n32 = 1'b1, wr_n32 = 1'b1;
    logic [3:0]  be_n32 = 4'hF, sel32;
    logic        wait_n32, buserr32, we32, cyc32, stb32;
    logic        ack32 = 1'b0, err32 = 1'b0, rty32 = 1'b0;

    moxie_wb_bridge #(
        .DATA_W(16), .ADDR_W(32), .TIMEOUT_CYC(8), .MAX_RETRY(3)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_addr_i(addr), .cpu_dout_i(dout), .cpu_din_o(din),
        .cpu_rd_n_i(rd_n), .cpu_wr_n_i(wr_n), .cpu_be_n_i(be_n),
        .cpu_wait_n_o(wait_n), .cpu_buserr_o(buserr),
        .wb_adr_o(adr), .wb_dat_o(wdat), .wb_dat_i(rdata), .wb_sel_o(sel),
        .wb_we_o(we), .wb_cyc_o(cyc), .wb_stb_o(stb),
        .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty)
    );

    moxie_wb_bridge #(
        .DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(8), .MAX_RETRY(3)
    ) dut32 (
        .clk_i(clk), .rst_i(rst),
        .cpu_addr_i(addr32), .cpu_dout_i(dout32), .cpu_din_o(din32),
        .cpu_rd_n_i(rd_n32), .cpu_wr_n_i(wr_n32), .cpu_be_n_i(be_n32),
        .cpu_wait_n_o(wait_n32), .cpu_buserr_o(buserr32),
        .wb_adr_o(adr32), .wb_dat_o(wdat32), .wb_dat_i(rdat32), .wb_sel_o(sel32),
        .wb_we_o(we32), .wb_cyc_o(cyc32), .wb_stb_o(stb32),
        .wb_ack_i(ack32), .wb_err_i(err32), .wb_rty_i(rty32)
    );

`ifdef WB_POSTED_WRITE_EN
    localparam int WrCyc = 1;
    localparam int RdCyc = 6;
`else
    localparam int WrCyc = 5;
    localparam int RdCyc = 3;
`endif

    localparam byte RAck = 8'd1;
    localparam byte RErr = 8'd2;
    localparam byte RRty = 8'd4;

    typedef struct {
        logic [15:0] din;
        logic        buserr;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    byte         resp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_rd = '0;

    // Slave: one scripted response per BUS cycle; empty script means silence.
    always @(negedge clk) begin
        if (cyc && stb && resp_q.size() > 0) begin
            ack <= resp_q[0][0];
            err <= resp_q[0][1];
            rty <= resp_q[0][2];
            resp_q.delete(0);
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            rty <= 1'b0;
        end
    end

    always @(negedge clk) ack32 <= cyc32 && stb32;

    int          cyc_hi = 0, cyc_rise = 0, buserr_hi = 0;
    logic        cyc_prev = 1'b0;
    logic [31:0] mon_adr = '0;
    logic [15:0] mon_dat = '0;
    logic [1:0]  mon_sel = '0;
    logic        mon_we = 1'b0;

    always @(negedge clk) begin
        if (cyc) begin
            cyc_hi  <= cyc_hi + 1;
            mon_adr <= adr;
            mon_dat <= wdat;
            mon_sel <= sel;
            mon_we  <= we;
        end
        if (cyc && !cyc_prev) cyc_rise <= cyc_rise + 1;
        if (buserr) buserr_hi <= buserr_hi + 1;
        cyc_prev <= cyc;
    end

    // Drives one CPU access from negedge+1 and holds it until wait_n is seen at a rising edge.
    task automatic cpu_run(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [15:0] d, input logic [1:0] bn,
                           output logic [15:0] din_obs, output logic err_obs,
                           output int cycles);
        addr = a; dout = d; be_n = bn;
        rd_n = !rd; wr_n = !wr;
        cycles = 0;
        #1;
        while (wait_n !== 1'b1 && cycles < 300) begin
            @(negedge clk); #1;
            cycles++;
        end
        din_obs = din;
        err_obs = buserr;
        @(posedge clk);
        cycles++;
        #1;
        rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({cyc, stb, we, buserr} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {cyc, stb, we, buserr});
        end
        total++;
        if (adr !== 32'h0 || wdat !== 16'h0) begin
            bad++; $display("FAIL reset_adr_dat got=%h/%h want=0/0", adr, wdat);
        end
        total++;
        if (sel !== 2'b00 || din !== 16'h0) begin
            bad++; $display("FAIL reset_sel_din got=%b/%h want=00/0000", sel, din);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        total++;
        if (wait_n !== 1'b1 || cyc !== 1'b0) begin
            bad++; $display("FAIL idle_wait got wait_n=%b cyc=%b want 1/0", wait_n, cyc);
        end
    endtask

    task automatic test_zero_wait_read();
        exp_t e; logic [15:0] d; logic be; int c; int h0;
        rdata = 16'hBEEF;
        resp_q.push_back(RAck);
        sb.push_back('{16'hBEEF, 1'b0, 3});
        last_rd = 16'hBEEF;
        h0 = cyc_hi;
        cpu_run(1'b1, 1'b0, 32'h0000_1003, 16'h0, 2'b11, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr) begin
            bad++; $display("FAIL zw_read_data got=%h/%b want=%h/%b", d, be, e.din, e.buserr);
        end
        total++;
        if (c !== e.cycles) begin
            bad++; $display("FAIL zw_read_cycles got=%0d want=%0d", c, e.cycles);
        end
        total++;
        if (mon_adr !== 32'h0000_1002 || mon_sel !== 2'b11 || mon_we !== 1'b0) begin
            bad++; $display("FAIL zw_read_bus got adr=%h sel=%b we=%b want 1002/11/0",
                            mon_adr, mon_sel, mon_we);
        end
        total++;
        if (cyc_hi - h0 !== 1) begin
            bad++; $display("FAIL zw_read_cyc_len got=%0d want=1", cyc_hi - h0);
        end
    endtask

    task automatic test_byte_write();
        exp_t e; logic [15:0] d; logic be; int c;
        resp_q.push_back(RAck);
        sb.push_back('{last_rd, 1'b0, 3});
        cpu_run(1'b0, 1'b1, 32'h0000_2001, 16'h12AA, 2'b01, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL wr16_result got=%h/%b/%0d want=%h/%b/%0d",
                            d, be, c, e.din, e.buserr, e.cycles);
        end
        total++;
        if (mon_adr !== 32'h0000_2000 || mon_sel !== 2'b10 || mon_we !== 1'b1 ||
            mon_dat !== 16'h12AA) begin
            bad++; $display("FAIL wr16_bus got adr=%h sel=%b we=%b dat=%h want 2000/10/1/12aa",
                            mon_adr, mon_sel, mon_we, mon_dat);
        end
    endtask

    task automatic test_byte_write32();
        int n; logic [31:0] a_obs, d_obs; logic [3:0] s_obs; logic we_obs;
        addr32 = 32'h4000_0007; dout32 = 32'h0000_00AA; be_n32 = 4'b1101; wr_n32 = 1'b0;
        n = 0;
        while (cyc32 !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        a_obs = adr32; d_obs = wdat32; s_obs = sel32; we_obs = we32;
        while (wait_n32 !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        wr_n32 = 1'b1;
        @(negedge clk); #1;
        total++;
        if (s_obs !== 4'b0010 || we_obs !== 1'b1 || d_obs !== 32'h0000_00AA) begin
            bad++; $display("FAIL wr32_lanes got sel=%b we=%b dat=%h want 0010/1/000000aa",
                            s_obs, we_obs, d_obs);
        end
        total++;
        if (a_obs !== 32'h4000_0004 || n !== 2) begin
            bad++; $display("FAIL wr32_adr got adr=%h waits=%0d want 40000004/2", a_obs, n);
        end
    endtask

    task automatic test_retry();
        exp_t e; logic [15:0] d; logic be; int c; int r0, b0;
        // Four retries exceed MAX_RETRY=3.
        repeat (4) resp_q.push_back(RRty);
        sb.push_back('{16'hFFFF, 1'b1, 9});
        last_rd = 16'hFFFF;
        r0 = cyc_rise; b0 = buserr_hi;
        cpu_run(1'b1, 1'b0, 32'h0000_0100, 16'h0, 2'b11, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL rty_exhaust got=%h/%b/%0d want=%h/%b/%0d",
                            d, be, c, e.din, e.buserr, e.cycles);
        end
        total++;
        if (cyc_rise - r0 !== 4 || buserr_hi - b0 !== 1) begin
            bad++; $display("FAIL rty_exhaust_bus got starts=%0d errs=%0d want 4/1",
                            cyc_rise - r0, buserr_hi - b0);
        end
        rdata = 16'h1234;
        resp_q.push_back(RRty); resp_q.push_back(RRty); resp_q.push_back(RAck);
        sb.push_back('{16'h1234, 1'b0, 7});
        last_rd = 16'h1234;
        r0 = cyc_rise; b0 = buserr_hi;
        cpu_run(1'b1, 1'b0, 32'h0000_0104, 16'h0, 2'b11, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL rty_ok got=%h/%b/%0d want=%h/%b/%0d",
                            d, be, c, e.din, e.buserr, e.cycles);
        end
        total++;
        if (cyc_rise - r0 !== 3 || buserr_hi - b0 !== 0) begin
            bad++; $display("FAIL rty_ok_bus got starts=%0d errs=%0d want 3/0",
                            cyc_rise - r0, buserr_hi - b0);
        end
    endtask

    task automatic test_priority();
        exp_t e; logic [15:0] d; logic be; int c;
        rdata = 16'h5555;
        resp_q.push_back(RErr | RAck);
        sb.push_back('{16'hFFFF, 1'b1, 3});
        cpu_run(1'b1, 1'b0, 32'h0000_0200, 16'h0, 2'b11, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL prio_err_ack got=%h/%b/%0d want=%h/%b/%0d",
                            d, be, c, e.din, e.buserr, e.cycles);
        end
        resp_q.push_back(RAck | RRty);
        sb.push_back('{16'h5555, 1'b0, 3});
        last_rd = 16'h5555;
        cpu_run(1'b1, 1'b0, 32'h0000_0202, 16'h0, 2'b11, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL prio_ack_rty got=%h/%b/%0d want=%h/%b/%0d",
                            d, be, c, e.din, e.buserr, e.cycles);
        end
    endtask

    task automatic test_timeout();
        exp_t e; logic [15:0] d; logic be; int c; int h0, b0;
        resp_q.delete();
        sb.push_back('{16'hFFFF, 1'b1, 10});
        last_rd = 16'hFFFF;
        h0 = cyc_hi; b0 = buserr_hi;
        cpu_run(1'b1, 1'b0, 32'h0000_0300, 16'h0, 2'b11, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL timeout got=%h/%b/%0d want=%h/%b/%0d",
                            d, be, c, e.din, e.buserr, e.cycles);
        end
        total++;
        if (cyc_hi - h0 !== 8 || buserr_hi - b0 !== 1) begin
            bad++; $display("FAIL timeout_bus got cyc_cycles=%0d errs=%0d want 8/1",
                            cyc_hi - h0, buserr_hi - b0);
        end
    endtask

    task automatic test_async_reset();
        exp_t e; logic [15:0] d; logic be; int c; int n;
        resp_q.delete();
        addr = 32'h0000_3000; rd_n = 1'b0;
        n = 0;
        while (cyc !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        total++;
        if (cyc !== 1'b1) begin
            bad++; $display("FAIL arst_start got cyc=%b want 1", cyc);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({cyc, stb} !== 2'b00 || din !== 16'h0) begin
            bad++; $display("FAIL arst_drop got cyc/stb=%b din=%h want 00/0000", {cyc, stb}, din);
        end
        rd_n = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        rdata = 16'h7777;
        resp_q.push_back(RAck);
        sb.push_back('{16'h7777, 1'b0, 3});
        last_rd = 16'h7777;
        cpu_run(1'b1, 1'b0, 32'h0000_3000, 16'h0, 2'b11, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL arst_recover got=%h/%b/%0d want=%h/%b/%0d",
                            d, be, c, e.din, e.buserr, e.cycles);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [15:0] d; logic be; int c;
        logic [15:0] vals [3];
        vals[0] = 16'hA001; vals[1] = 16'hB002; vals[2] = 16'hC003;
        for (int i = 0; i < 3; i++) begin
            rdata = vals[i];
            resp_q.push_back(RAck);
            sb.push_back('{vals[i], 1'b0, 3});
            last_rd = vals[i];
            cpu_run(1'b1, 1'b0, 32'h0000_0400 + 32'(2 * i), 16'h0, 2'b11, d, be, c);
            e = sb.pop_front();
            total++;
            if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
                bad++; $display("FAIL b2b_%0d got=%h/%b/%0d want=%h/%b/%0d",
                                i, d, be, c, e.din, e.buserr, e.cycles);
            end
        end
    endtask

    task automatic test_write_then_read();
        exp_t e; logic [15:0] d; logic be; int c; int r0;
        rdata = 16'h5A5A;
        resp_q.push_back(8'd0); resp_q.push_back(8'd0);
        resp_q.push_back(RAck); resp_q.push_back(RAck);
        sb.push_back('{last_rd, 1'b0, WrCyc});
        sb.push_back('{16'h5A5A, 1'b0, RdCyc});
        r0 = cyc_rise;
        cpu_run(1'b0, 1'b1, 32'h0000_0500, 16'hC0DE, 2'b00, d, be, c);
        e = sb.pop_front();
        total++;
        if (be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL wr_rd_write got=%b/%0d want=%b/%0d", be, c, e.buserr, e.cycles);
        end
        cpu_run(1'b1, 1'b0, 32'h0000_0600, 16'h0, 2'b11, d, be, c);
        e = sb.pop_front();
        total++;
        if (d !== e.din || be !== e.buserr || c !== e.cycles) begin
            bad++; $display("FAIL wr_rd_read got=%h/%b/%0d want=%h/%b/%0d",
                            d, be, c, e.din, e.buserr, e.cycles);
        end
        total++;
        if (cyc_rise - r0 !== 2) begin
            bad++; $display("FAIL wr_rd_starts got=%0d want=2", cyc_rise - r0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout sim did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait_read();
        test_byte_write();
        test_byte_write32();
        test_retry();
        test_priority();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        test_write_then_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
